// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage mul/div request, control and HI/LO result bundle.
// master drives the request side, slave is the iterative unit.
interface ex_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             hold;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (
      output start, op, src_a, src_b, flush, hold,
      input  busy, done, hi_out, lo_out
   );

   modport slave (
      input  start, op, src_a, src_b, flush, hold,
      output busy, done, hi_out, lo_out
   );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: radix-2 shift-add multiply / restoring divide, one bit
// per cycle, 64-bit HI/LO result, busy stalls the front of the pipe.
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);
   localparam int W = WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t         state_q;
   logic [5:0]     cnt_q;
   logic [2*W-1:0] x_q;
   logic [W-1:0]   y_q;
   logic           neg_q;
   logic           negr_q;
   logic           divz_q;
   logic [W-1:0]   rawa_q;
   logic [W-1:0]   hi_q;
   logic [W-1:0]   lo_q;
   logic           done_q;

   logic           sgn;
   logic [W-1:0]   abs_a;
   logic [W-1:0]   abs_b;
   logic [W:0]     msum;
   logic [2*W-1:0] mul_d;
   logic [W:0]     sh;
   logic [W:0]     diff;
   logic           ge;
   logic [2*W-1:0] div_d;
   logic [2*W-1:0] mres;
   logic [W-1:0]   qres;
   logic [W-1:0]   rres;
   logic           last;

   assign bus.busy = (state_q == S_IDLE && bus.start && !bus.flush)
                  || state_q == S_MUL
                  || state_q == S_DIV;
   assign bus.done   = done_q;
   assign bus.hi_out = hi_q;
   assign bus.lo_out = lo_q;

   // Operand magnitudes, one iteration step for each unit, sign fix-up.
   always_comb begin
      sgn   = ~bus.op[0];
      abs_a = bus.src_a;
      abs_b = bus.src_b;
      if (sgn && bus.src_a[W-1]) abs_a = -bus.src_a;
      if (sgn && bus.src_b[W-1]) abs_b = -bus.src_b;
      msum  = {1'b0, x_q[2*W-1:W]};
      if (x_q[0]) msum = msum + {1'b0, y_q};
      mul_d = {msum, x_q[W-1:1]};
      sh    = {x_q[2*W-1:W], x_q[W-1]};
      diff  = sh - {1'b0, y_q};
      ge    = sh >= {1'b0, y_q};
      div_d = {(ge ? diff[W-1:0] : sh[W-1:0]), x_q[W-2:0], ge};
      mres  = neg_q ? -mul_d : mul_d;
      qres  = neg_q ? -div_d[W-1:0] : div_d[W-1:0];
      rres  = negr_q ? -div_d[2*W-1:W] : div_d[2*W-1:W];
      last  = cnt_q == 6'(W-1);
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         neg_q   <= 1'b0;
         negr_q  <= 1'b0;
         divz_q  <= 1'b0;
         rawa_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else if (bus.flush) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  x_q    <= {{W{1'b0}},
                             (bus.op[1] ? abs_a : abs_b)};
                  y_q    <= bus.op[1] ? abs_b : abs_a;
                  neg_q  <= sgn & (bus.src_a[W-1] ^ bus.src_b[W-1]);
                  negr_q <= sgn & bus.src_a[W-1];
                  divz_q <= bus.src_b == '0;
                  rawa_q <= bus.src_a;
                  cnt_q  <= '0;
                  state_q <= bus.op[1] ? S_DIV : S_MUL;
               end
            end
            S_MUL: begin
               x_q   <= mul_d;
               cnt_q <= cnt_q + 6'd1;
               if (last) begin
                  hi_q    <= mres[2*W-1:W];
                  lo_q    <= mres[W-1:0];
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DIV: begin
               x_q   <= div_d;
               cnt_q <= cnt_q + 6'd1;
               if (last) begin
                  hi_q    <= divz_q ? rawa_q : rres;
                  lo_q    <= divz_q ? '1 : qres;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               if (!bus.hold) begin
                  done_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage.
- Consumes the operands and operation delivered by the ID/EX pipeline register (RD1E/RD2E-derived sources, mul/div decode from ALUCtrlE).
- Produces a 64-bit HI/LO result for the HI/LO write path. Asserts busy so the hazard unit stalls IF/ID/EX while an operation runs.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- WIDTH, 32, operand width. The design is verified only at 32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- start  input  1  EX instruction requires mul/div. Level signal, sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  WIDTH  rs operand (multiplicand / dividend)
- src_b  input  WIDTH  rt operand (multiplier / divisor)
- flush  input  1  cancel in-flight operation (exception / EX flush)
- hold  input  1  downstream stall; keeps a finished result presented
- busy  output  1  combinational; stall request to the hazard unit
- done  output  1  result valid
- hi_out  output  WIDTH  product high word / remainder
- lo_out  output  WIDTH  product low word / quotient

Behaviour:
- States: IDLE, MUL, DIV, DONE. A counter of 6 bits counts iterations 0..31.
- Reset (rst=0 at a clock edge):
  - state goes to IDLE, counter 0.
  - hi_out=0, lo_out=0, done=0, busy=0. All internal registers are cleared.
  - Reset is valid mid-operation and discards it.
- flush has priority over everything except rst.
  - In any state, the next state is IDLE and done=0 on the next cycle.
  - hi_out/lo_out keep their previous values.
  - start in the same cycle as flush is ignored.
- IDLE:
  - If start=1 and flush=0, latch |src_a|, |src_b| and the sign flags, then go to MUL (op[1]=0) or DIV (op[1]=1).
  - Signed ops use magnitudes; unsigned ops use raw values.
- busy = (IDLE & start & ~flush) | MUL | DIV. busy is 0 in DONE and in IDLE without start.
- MUL/DIV:
  - One iteration per cycle for 32 cycles.
  - On the edge completing iteration 31, apply the sign fix-up, register the result into hi_out/lo_out, and enter DONE.
- Latency: start is accepted in cycle T. busy is high for cycles T..T+32. done=1 first in cycle T+33.
- DONE:
  - done=1 and outputs are stable.
  - If hold=1, stay in DONE (start is ignored, no retrigger).
  - If hold=0, go to IDLE next edge. done is high for exactly one cycle when hold=0.
  - A new start is accepted no earlier than the cycle after the last done cycle.
- Signed multiply: negate the 64-bit product if the sign of src_a differs from the sign of src_b.
- Signed divide:
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (wrap, no trap).
- Divide by zero (DIV or DIVU):
  - Completes with normal latency.
  - lo=0xFFFFFFFF, hi=src_a (the raw value, no sign fix-up).
- op, src_a and src_b are sampled only at acceptance. Later changes have no effect on an in-flight operation.

Test Plan:
- rst=0 for 2 cycles, then release -> busy=0, done=0, hi_out=lo_out=0.
- MULTU 0xFFFFFFFF*0x00000002 with start in cycle T -> busy high T..T+32, done in T+33, hi=0x00000001, lo=0xFFFFFFFE.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIVU 100/7 started in T, flush in T+10 -> IDLE at T+11, busy=0, no done, hi/lo unchanged. Then start MULTU 3*4 at T+12 -> done at T+45, lo=12, hi=0.
- MULTU 6*7 with hold=1 for 3 cycles on completion and start held high -> done high 4 cycles, lo=42 stable, no new operation. After hold drops, IDLE next cycle.
